// File: rtl/alu_exec_unit.sv
// Stack-machine ALU execute unit: decodes an 8-bit instruction, executes it, keeps a carry flag
// and returns results through a registered valid/ready output. Define ALU_EXEC_MUL_EN for the iterative multiplier.
module alu_exec_unit #(
  parameter int WORD_WIDTH = 32,
  parameter int DC_COUNT   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     instruction,
  input  logic [WORD_WIDTH-1:0]          top,
  input  logic [WORD_WIDTH-1:0]          second,
  input  logic [DC_COUNT*WORD_WIDTH-1:0] dc_vals,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_WIDTH-1:0]          out_result,
  output logic                           out_illegal,
  output logic                           carry,
  output logic                           dbg_state
);

  localparam int W    = WORD_WIDTH;
  localparam int SELW = $clog2(DC_COUNT);

  localparam logic [3:0] CLS_ADDZ = 4'd0;
  localparam logic [3:0] CLS_ADDC = 4'd1;
  localparam logic [3:0] CLS_SUB  = 4'd2;
  localparam logic [3:0] CLS_AND  = 4'd3;
  localparam logic [3:0] CLS_OR   = 4'd4;
  localparam logic [3:0] CLS_XOR  = 4'd5;
  localparam logic [3:0] CLS_MUL  = 4'd6;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
  // and a held valid keeps its payload stable until the transfer.

  logic [3:0]      op_class;
  logic [SELW-1:0] dc_sel;
  logic [W-1:0]    dc_operand;
  logic [W:0]      sum;
  logic [W-1:0]    simple_res;
  logic            simple_illegal;
  logic            writes_carry;
  logic            accept;
  logic            idle;
  logic            is_mul;
  logic            mul_done;
  logic [W-1:0]    mul_result;

  assign op_class = instruction[7:4];
  assign dc_sel   = instruction[SELW-1:0];

  if (SELW < 4) begin : g_ignored_bits
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[3:SELW];
  end

  always_comb begin
    dc_operand = '0;
    for (int i = 0; i < DC_COUNT; i++) begin
      if (dc_sel == SELW'(i)) dc_operand = dc_vals[i*W +: W];
    end
  end

  // Single-cycle classes; SUB is formed as second + ~top + 1 so carry-out means "no borrow".
  always_comb begin
    sum            = '0;
    simple_res     = '0;
    simple_illegal = 1'b0;
    writes_carry   = 1'b0;
    case (op_class)
      CLS_ADDZ: begin
        sum          = {1'b0, dc_operand} + {1'b0, top};
        writes_carry = 1'b1;
      end
      CLS_ADDC: begin
        sum          = {1'b0, top} + {1'b0, second} + {{W{1'b0}}, carry};
        writes_carry = 1'b1;
      end
      CLS_SUB: begin
        sum          = {1'b0, second} + {1'b0, ~top} + {{W{1'b0}}, 1'b1};
        writes_carry = 1'b1;
      end
      CLS_AND: simple_res = top & second;
      CLS_OR:  simple_res = top | second;
      CLS_XOR: simple_res = top ^ second;
      default: simple_illegal = 1'b1;
    endcase
    if (writes_carry) simple_res = sum[W-1:0];
  end

  assign in_ready = !reset && idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_MUL_EN
  localparam int CNT_W = $clog2(W);

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;
  state_t          state, state_next;
  logic [W-1:0]    mcand, mplier, acc;
  logic [CNT_W-1:0] bit_cnt;

  assign is_mul     = (op_class == CLS_MUL);
  assign idle       = (state == S_IDLE);
  assign dbg_state  = (state == S_MUL_BUSY);
  assign mul_done   = (state == S_MUL_BUSY) && (bit_cnt == '0);
  assign mul_result = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (accept && is_mul) state_next = S_MUL_BUSY;
      S_MUL_BUSY: if (bit_cnt == '0)    state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // One shift-add step per busy cycle; bits above W are dropped by the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
    end else if (accept && is_mul) begin
      mcand   <= top;
      mplier  <= second;
      acc     <= '0;
      bit_cnt <= CNT_W'(W - 1);
    end else if (state == S_MUL_BUSY) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      acc     <= mul_result;
      bit_cnt <= bit_cnt - 1'b1;
    end
  end
`else
  assign is_mul     = 1'b0;
  assign idle       = 1'b1;
  assign dbg_state  = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = '0;
`endif

  // A new result written on the same edge as a drain wins, giving one result per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      carry       <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid   <= 1'b1;
      out_result  <= simple_res;
      out_illegal <= simple_illegal;
      if (writes_carry) carry <= sum[W];
    end else if (mul_done) begin
      out_valid   <= 1'b1;
      out_result  <= mul_result;
      out_illegal <= 1'b0;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic against an
// arithmetic reference model and an expected-result queue. Honours ALU_EXEC_MUL_EN like the design.
module tb_alu_exec_unit;
  localparam int W  = 32;
  localparam int DC = 4;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    instruction;
  logic [W-1:0]  top, second, out_result;
  logic [DC*W-1:0] dc_vals;
  logic          out_valid, out_ready, out_illegal, carry, dbg_state;

  int            n_cmp = 0;
  int            n_err = 0;
  logic          exp_carry;
  logic [W:0]    exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WORD_WIDTH(W), .DC_COUNT(DC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .top(top), .second(second), .dc_vals(dc_vals),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal), .carry(carry), .dbg_state(dbg_state)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: results from the class definitions using 64-bit arithmetic.
  function automatic void ref_op(input logic [3:0] cls, input int sel, input logic [W-1:0] t,
                                 input logic [W-1:0] s, input logic [DC*W-1:0] dc, input logic cin,
                                 output logic [W-1:0] res, output logic ill, output logic cout);
    longint unsigned a, b, d, sum;
    a = t; b = s; d = dc[sel*W +: W];
    res = '0; ill = 1'b0; cout = cin;
    case (cls)
      4'd0: begin sum = d + a;       res = W'(sum); cout = (sum >> W) != 0; end
      4'd1: begin sum = a + b + cin; res = W'(sum); cout = (sum >> W) != 0; end
      4'd2: begin res = W'(b - a); cout = (b >= a); end
      4'd3: res = t & s;
      4'd4: res = t | s;
      4'd5: res = t ^ s;
      4'd6: if (MUL_EN) res = W'(a * b); else ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic set_op(input logic [3:0] cls, input int sel, input logic [W-1:0] t, input logic [W-1:0] s);
    instruction = {cls, 2'($urandom_range(0, 3)), 2'(sel)};
    top = t;
    second = s;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; top = '0; second = '0; dc_vals = '0;
    repeat (3) step;
    n_cmp++;
    if ({in_ready, out_valid, out_illegal, carry, out_result} !== {4'b0000, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b ill=%b c=%b res=%h, want all zero",
               in_ready, out_valid, out_illegal, carry, out_result);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    exp_carry = 1'b0;
  endtask

  task automatic test_addz_addc;
    logic [W-1:0] r; logic il, c;
    out_ready = 1'b0;
    dc_vals = {$urandom, $urandom, $urandom, $urandom};
    dc_vals[2*W +: W] = 32'hFFFF_FFFF;
    set_op(4'd0, 2, 32'd1, $urandom);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_illegal, carry, out_result} !== {3'b101, 32'h0}) begin
      n_err++;
      $display("FAIL addz_wrap: vld=%b ill=%b c=%b res=%h, want 1 0 1 00000000", out_valid, out_illegal, carry, out_result);
    end
    exp_carry = 1'b1;
    out_ready = 1'b1;
    set_op(4'd1, $urandom_range(0, 3), 32'd5, 32'd7);
    in_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL addc_ready: got %b want 1", in_ready); end
    step;
    n_cmp++;
    if ({out_valid, out_illegal, carry, out_result} !== {3'b100, 32'd13}) begin
      n_err++;
      $display("FAIL addc_chain: vld=%b ill=%b c=%b res=%0d, want 1 0 0 13", out_valid, out_illegal, carry, out_result);
    end
    exp_carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(4'd1, 0, (i % 2 == 0) ? 32'hFFFF_FFF0 + W'(i) : $urandom, $urandom);
      ref_op(4'd1, 0, top, second, dc_vals, exp_carry, r, il, c);
      step;
      n_cmp++;
      if ({out_valid, out_illegal, carry, out_result} !== {1'b1, il, c, r}) begin
        n_err++;
        $display("FAIL addc_b2b[%0d]: vld=%b c=%b res=%h, want 1 %b %h", i, out_valid, carry, out_result, c, r);
      end
      exp_carry = c;
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_sub;
    out_ready = 1'b1;
    set_op(4'd2, 0, 32'd5, 32'd3);
    in_valid = 1'b1;
    step;
    n_cmp++;
    if ({out_valid, carry, out_result} !== {2'b10, 32'hFFFF_FFFE}) begin
      n_err++;
      $display("FAIL sub_borrow: vld=%b c=%b res=%h, want 1 0 fffffffe", out_valid, carry, out_result);
    end
    set_op(4'd2, 0, 32'd3, 32'd5);
    step;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, carry, out_result} !== {2'b11, 32'd2}) begin
      n_err++;
      $display("FAIL sub_noborrow: vld=%b c=%b res=%h, want 1 1 00000002", out_valid, carry, out_result);
    end
    exp_carry = 1'b1;
    step;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] r; logic il, c; logic [3:0] cls; int sel; int not_ready;
    out_ready = 1'b1;
    not_ready = 0;
    for (int i = 0; i < 40; i++) begin
      cls = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      if (MUL_EN && cls == 4'd6) cls = 4'd5;
      sel = $urandom_range(0, DC - 1);
      dc_vals = {$urandom, $urandom, $urandom, $urandom};
      set_op(cls, sel, $urandom, $urandom);
      ref_op(cls, sel, top, second, dc_vals, exp_carry, r, il, c);
      in_valid = 1'b1;
      #1;
      if (in_ready !== 1'b1) not_ready++;
      step;
      n_cmp++;
      if ({out_valid, out_illegal, carry, out_result} !== {1'b1, il, c, r}) begin
        n_err++;
        $display("FAIL b2b[%0d] cls=%0d: vld=%b ill=%b c=%b res=%h, want 1 %b %b %h",
                 i, cls, out_valid, out_illegal, carry, out_result, il, c, r);
      end
      exp_carry = c;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (not_ready != 0) begin n_err++; $display("FAIL b2b_ready: in_ready low %0d times, want 0", not_ready); end
    step;
  endtask

  task automatic test_mul;
    logic [W-1:0] r; logic il, c; int n, busy_ready;
    out_ready = 1'b1;
    dc_vals[0 +: W] = 32'hFFFF_FFFF;
    set_op(4'd0, 0, 32'd1, $urandom);
    in_valid = 1'b1;
    step;
    exp_carry = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_op(4'd6, 0, 32'h0001_0001, 32'h0001_0003);
      else        set_op(4'd6, 0, $urandom, $urandom);
      ref_op(4'd6, 0, top, second, dc_vals, exp_carry, r, il, c);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
`ifdef ALU_EXEC_MUL_EN
      n = 0; busy_ready = 0;
      while (!out_valid && n < 100) begin
        if (in_ready) busy_ready++;
        step;
        n++;
      end
      n_cmp++;
      if (n != W || busy_ready != 0) begin
        n_err++;
        $display("FAIL mul_latency[%0d]: %0d cycles (ready high %0d), want %0d (0)", k, n, busy_ready, W);
      end
`endif
      n_cmp++;
      if ({out_valid, out_illegal, carry, out_result} !== {1'b1, il, exp_carry, r}) begin
        n_err++;
        $display("FAIL mul[%0d]: vld=%b ill=%b c=%b res=%h, want 1 %b %b %h",
                 k, out_valid, out_illegal, carry, out_result, il, exp_carry, r);
      end
      if (k == 0) begin
        n_cmp++;
        if (out_result !== (MUL_EN ? 32'h0004_0003 : 32'h0)) begin
          n_err++;
          $display("FAIL mul_fixed: res=%h", out_result);
        end
      end
      step;
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] held, r; logic il, c; int bad;
    out_ready = 1'b0;
    set_op(4'd5, 0, $urandom, $urandom);
    held = top ^ second;
    in_valid = 1'b1;
    step;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      set_op(4'd1, 0, $urandom, $urandom);
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== held) bad++;
      step;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL stall_hold: %0d bad cycles, want 0 (held %h)", bad, held); end
    ref_op(4'd1, 0, top, second, dc_vals, exp_carry, r, il, c);
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, carry, out_result} !== {1'b1, c, r}) begin
      n_err++;
      $display("FAIL stall_next: vld=%b c=%b res=%h, want 1 %b %h", out_valid, carry, out_result, c, r);
    end
    exp_carry = c;
    step;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_random_handshake;
    logic [W-1:0] r; logic il, c; logic [3:0] cls; int sel, n; logic [W:0] front;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cls = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, DC - 1);
      dc_vals = {$urandom, $urandom, $urandom, $urandom};
      set_op(cls, sel, $urandom, $urandom);
      #1;
      if (out_valid && out_ready) begin
        front = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'bx}}};
        n_cmp++;
        if ({out_illegal, out_result} !== front) begin
          n_err++;
          $display("FAIL rand_result cyc=%0d: ill=%b res=%h, want %b %h", cyc, out_illegal, out_result, front[W], front[W-1:0]);
        end
      end
      if (in_valid && in_ready) begin
        ref_op(cls, sel, top, second, dc_vals, exp_carry, r, il, c);
        exp_q.push_back({il, r});
        exp_carry = c;
      end
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 100) begin
      if (out_valid) begin
        front = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, {W{1'bx}}};
        n_cmp++;
        if ({out_illegal, out_result} !== front) begin
          n_err++;
          $display("FAIL rand_drain: ill=%b res=%h, want %b %h", out_illegal, out_result, front[W], front[W-1:0]);
        end
      end
      step;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || carry !== exp_carry) begin
      n_err++;
      $display("FAIL rand_end: %0d results missing, carry=%b want %b", exp_q.size(), carry, exp_carry);
    end
  endtask

  task automatic test_reset_mid_mul;
    int stale;
    out_ready = 1'b1;
    dc_vals[0 +: W] = 32'hFFFF_FFFF;
    set_op(4'd0, 0, 32'd3, $urandom);
    in_valid = 1'b1;
    step;
    set_op(4'd6, 0, $urandom, $urandom);
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (10) step;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_illegal, carry, out_result} !== {4'b0000, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL midmul_reset: rdy=%b vld=%b ill=%b c=%b res=%h, want all zero",
               in_ready, out_valid, out_illegal, carry, out_result);
    end
    step;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midmul_ready: got %b want 1", in_ready); end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stale++;
      step;
    end
    n_cmp++;
    if (stale != 0 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL midmul_stale: %0d valid cycles carry=%b, want 0 0", stale, carry);
    end
  endtask

  initial begin
    test_reset;
    test_addz_addc;
    test_sub;
    test_back_to_back;
    test_mul;
    test_stall;
    test_random_handshake;
    test_reset_mid_mul;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
